// File: rtl/imm_decode_stage.sv
// Purpose: RV32I/RV64I immediate decode with pc+imm target and illegal-opcode flag.
// Latency: an accepted instruction appears on out_* on the next cycle; 1/cycle throughput.
// Backpressure: a 2-entry skid (main + skid) keeps in_ready a flop; in_ready drops only when both entries are full.
// Ports: clk/rst (sync, active-high), flush (drop all entries),
//        in_valid/in_ready/in_instr/in_pc (upstream handshake),
//        out_valid/out_ready/out_imm/out_type/out_target/out_pc/out_illegal (downstream handshake).
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
  localparam logic [2:0] T_ZIMM  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state_q, state_d;
  ent_t   main_q, skid_q, dec;
  logic   load_main, load_skid, main_from_skid;
  logic   accept, drain;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Decode of the instruction currently offered upstream; captured only on accept.
  // Sign extension uses a signed source cast up to XLEN so the same code serves 32 and 64.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.typ     = T_NONE;
    dec.imm     = '0;
    dec.illegal = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift immediates: funct7 bits above the shamt field are not part of the value.
          dec.typ = T_SHAMT;
          dec.imm = XLEN'(in_instr[20 +: SHAMT_W]);
        end else begin
          dec.typ = T_I;
          dec.imm = XLEN'($signed(in_instr[31:20]));
        end
      end
      7'b0000011, 7'b1100111: begin
        dec.typ = T_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec.typ = T_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec.typ = T_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.typ = T_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.typ = T_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec.typ = T_ZIMM;
          dec.imm = XLEN'(in_instr[19:15]);
        end
      end
      7'b0110011, 7'b0001111: begin
        dec.typ = T_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // Wraps naturally at XLEN bits.
    dec.target = in_pc + dec.imm;
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register; in_ready is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != S_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    out_valid      = (state_q != S_EMPTY);
    if (flush) begin
      // Flush beats a same-cycle accept: nothing is loaded.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_d   = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !drain) begin
            load_skid = 1'b1;
            state_d   = S_TWO;
          end else if (accept && drain) begin
            load_main = 1'b1;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a drain can happen; the older skid entry moves up.
          if (drain) begin
            main_from_skid = 1'b1;
            state_d        = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_target  = main_q.target;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  typ;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic [31:0] out_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_pc;
  logic        w_out_valid;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_type;
  logic [63:0] w_out_target;
  logic [63:0] w_out_pc;
  logic        w_out_illegal;

  int   n_vec;
  int   n_err;
  int   n_out;
  exp_t q[$];
  exp_t cur;

  imm_decode_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
    .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .SHAMT_W(6)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_imm(w_out_imm), .out_type(w_out_type),
    .out_target(w_out_target), .out_pc(w_out_pc), .out_illegal(w_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.pc;
    cur      = v.e;
  endtask

  // One clock: scoreboard pop on output transfer, push on input accept, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL spurious_out observed imm=%0h pc=%0h required no output", out_imm, out_pc);
        end else begin
          e = q.pop_front();
          n_out++;
          chk("imm",     {32'b0, out_imm},    {32'b0, e.imm});
          chk("type",    {61'b0, out_type},   {61'b0, e.typ});
          chk("target",  {32'b0, out_target}, {32'b0, e.tgt});
          chk("pc",      {32'b0, out_pc},     {32'b0, e.pc});
          chk("illegal", {63'b0, out_illegal}, {63'b0, e.ill});
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];
  vec_t va, vb, vc, vd, ve, vf, vg;
  int   base;

  initial begin
    n_vec = 0; n_err = 0; n_out = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0;
    cur = '0;

    //            instr          pc             imm            typ   target         pc             ill
    vecs[0]  = '{32'hFFF00093, 32'h0000_0000, '{32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 32'h0000_0000, 1'b0}};
    vecs[1]  = '{32'hFE000EE3, 32'h0000_0100, '{32'hFFFFFFFC, 3'd3, 32'h000000FC, 32'h0000_0100, 1'b0}};
    vecs[2]  = '{32'h123452B7, 32'h0000_0200, '{32'h12345000, 3'd4, 32'h12345200, 32'h0000_0200, 1'b0}};
    vecs[3]  = '{32'h0010006F, 32'h0000_0300, '{32'h00000800, 3'd5, 32'h00000B00, 32'h0000_0300, 1'b0}};
    vecs[4]  = '{32'hFE512C23, 32'h0000_0400, '{32'hFFFFFFF8, 3'd2, 32'h000003F8, 32'h0000_0400, 1'b0}};
    vecs[5]  = '{32'h300FD0F3, 32'h0000_0500, '{32'h0000001F, 3'd7, 32'h0000051F, 32'h0000_0500, 1'b0}};
    vecs[6]  = '{32'h002081B3, 32'h0000_0600, '{32'h00000000, 3'd0, 32'h00000600, 32'h0000_0600, 1'b0}};
    vecs[7]  = '{32'h0000007F, 32'h0000_0700, '{32'h00000000, 3'd0, 32'h00000700, 32'h0000_0700, 1'b1}};
    vecs[8]  = '{32'h41F0D093, 32'h0000_0800, '{32'h0000001F, 3'd6, 32'h0000081F, 32'h0000_0800, 1'b0}};
    vecs[9]  = '{32'hFFFFF017, 32'h0000_2000, '{32'hFFFFF000, 3'd4, 32'h00001000, 32'h0000_2000, 1'b0}};
    vecs[10] = '{32'h7FF12083, 32'h0000_0900, '{32'h000007FF, 3'd1, 32'h000010FF, 32'h0000_0900, 1'b0}};
    vecs[11] = '{32'h00000073, 32'h0000_0A00, '{32'h00000000, 3'd0, 32'h00000A00, 32'h0000_0A00, 1'b0}};
    vecs[12] = '{32'h0000000F, 32'h0000_0B00, '{32'h00000000, 3'd0, 32'h00000B00, 32'h0000_0B00, 1'b0}};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", {63'b0, out_valid},  64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},   64'd1);
    chk("rst_imm",       {32'b0, out_imm},    64'd0);
    chk("rst_type",      {61'b0, out_type},   64'd0);
    chk("rst_target",    {32'b0, out_target}, 64'd0);
    chk("rst_pc",        {32'b0, out_pc},     64'd0);
    chk("rst_illegal",   {63'b0, out_illegal}, 64'd0);

    // First instruction: one-cycle latency
    out_ready = 1'b1;
    drive(vecs[0]);
    tick();
    chk("latency_valid", {63'b0, out_valid}, 64'd1);
    chk("latency_imm",   {32'b0, out_imm},   64'hFFFFFFFF);

    // Back-to-back stream at full rate
    for (int i = 1; i < 13; i++) begin
      drive(vecs[i]);
      tick();
      chk("stream_in_ready", {63'b0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("stream_count", 64'(n_out), 64'd13);

    // Backpressure: three back-to-back with out_ready low
    va = vecs[2]; va.pc = 32'h1000; va.e.pc = 32'h1000; va.e.tgt = 32'h12346000;
    vb = vecs[6]; vb.pc = 32'h1004; vb.e.pc = 32'h1004; vb.e.tgt = 32'h00001004;
    vc = vecs[0]; vc.pc = 32'h1008; vc.e.pc = 32'h1008; vc.e.tgt = 32'h00001007;
    base = n_out;
    out_ready = 1'b0;
    drive(va); tick();
    chk("bp_ready_one", {63'b0, in_ready}, 64'd1);
    drive(vb); tick();
    chk("bp_ready_two", {63'b0, in_ready}, 64'd0);
    drive(vc); tick();
    chk("bp_ready_held", {63'b0, in_ready}, 64'd0);
    chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_hold_imm",   {32'b0, out_imm},   64'h12345000);
    chk("bp_hold_pc",    {32'b0, out_pc},    64'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (in_valid && !(in_ready)); i++) tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("bp_count", 64'(n_out - base), 64'd3);

    // Flush while full with a same-cycle input
    vd = vecs[3]; vd.pc = 32'h2000; vd.e.pc = 32'h2000; vd.e.tgt = 32'h00002800;
    ve = vecs[1]; ve.pc = 32'h2004; ve.e.pc = 32'h2004; ve.e.tgt = 32'h00002000;
    vf = vecs[7]; vf.pc = 32'h2008; vf.e.pc = 32'h2008; vf.e.tgt = 32'h00002008;
    out_ready = 1'b0;
    drive(vd); tick();
    drive(ve); tick();
    chk("fl_full_ready", {63'b0, in_ready}, 64'd0);
    drive(vf); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_in_ready",  {63'b0, in_ready},  64'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("fl_still_empty", {63'b0, out_valid}, 64'd0);
    vg = vecs[11]; vg.pc = 32'h3000; vg.e.pc = 32'h3000; vg.e.tgt = 32'h00003000;
    drive(vg); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();

    // XLEN=64 instance
    w_in_valid = 1'b1; w_in_instr = 32'h03F01013; w_in_pc = 64'h1_0000_0000;
    @(posedge clk); #1;
    w_in_instr = 32'h0000007F; w_in_pc = 64'h1_0000_0004;
    chk("x64_slli_valid",  {63'b0, w_out_valid}, 64'd1);
    chk("x64_slli_imm",    w_out_imm,   64'h3F);
    chk("x64_slli_type",   {61'b0, w_out_type}, 64'd6);
    chk("x64_slli_target", w_out_target, 64'h1_0000_003F);
    @(posedge clk); #1;
    w_in_instr = 32'h800000B7; w_in_pc = 64'h10;
    chk("x64_ill_flag", {63'b0, w_out_illegal}, 64'd1);
    chk("x64_ill_imm",  w_out_imm, 64'd0);
    chk("x64_ill_type", {61'b0, w_out_type}, 64'd0);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    chk("x64_lui_imm",  w_out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("x64_lui_type", {61'b0, w_out_type}, 64'd4);
    chk("x64_lui_target", w_out_target, 64'hFFFF_FFFF_8000_0010);

    chk("leftover", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
